// File: rtl/sha256_mining_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha256_mining_sequencer: double-SHA-256 nonce sequencer for the      |
// | round datapath / H accumulators. Option macro: MIDSTATE_EN. Rev 1.0  |
// +----------------------------------------------------------------------+
module sha256_mining_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] nonce_start,
  input  logic [31:0] nonce_end,
  input  logic        target_hit,
  output logic        h_init,
  output logic        init_sel,
  output logic        round_en,
  output logic [5:0]  round,
  output logic        h_acc,
  output logic [1:0]  msg_sel,
  output logic        digest_latch,
  output logic [31:0] nonce,
  output logic        busy,
  output logic        hash_valid,
  output logic        found,
  output logic        exhausted
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_ACC   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
`ifdef MIDSTATE_EN
  localparam logic [1:0] FIRST_PHASE = P1;
`else
  localparam logic [1:0] FIRST_PHASE = P0;
`endif

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [5:0]  round_q, round_d;
  logic [31:0] nonce_q, nonce_d;
  logic [31:0] nonce_end_q, nonce_end_d;
  logic        found_q, found_d;
  logic        exhausted_q, exhausted_d;
  logic        h_init_q, h_init_d;
  logic        init_sel_q, init_sel_d;
  logic        round_en_q, round_en_d;
  logic        h_acc_q, h_acc_d;
  logic        digest_latch_q, digest_latch_d;
  logic        busy_q, busy_d;
  logic        hash_valid_q, hash_valid_d;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    round_d     = round_q;
    nonce_d     = nonce_q;
    nonce_end_d = nonce_end_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;

    if (state_q != ST_IDLE && abort) begin
      state_d = ST_IDLE;
      round_d = 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            nonce_d     = nonce_start;
            nonce_end_d = nonce_end;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            phase_d     = FIRST_PHASE;
            state_d     = ST_INIT;
          end
        end
        ST_INIT: begin
          round_d = 6'd0;
          state_d = ST_ROUND;
        end
        ST_ROUND: begin
          if (round_q == 6'd63) begin
            round_d = 6'd0;
            state_d = ST_ACC;
          end else begin
            round_d = round_q + 6'd1;
          end
        end
        ST_ACC: begin
          // Chunk 1 chains straight off chunk 0's H; the second hash restarts from IV.
          case (phase_q)
            P0: begin
              phase_d = P1;
              state_d = ST_ROUND;
            end
            P1: begin
              phase_d = P2;
              state_d = ST_INIT;
            end
            default: state_d = ST_DONE;
          endcase
        end
        ST_DONE: begin
          if (target_hit) begin
            found_d = 1'b1;
            state_d = ST_IDLE;
          end else if (nonce_q == nonce_end_q) begin
            exhausted_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            nonce_d = nonce_q + 32'd1;
            phase_d = FIRST_PHASE;
            state_d = ST_INIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          round_d = 6'd0;
        end
      endcase
    end

    // Strobes are decoded from the next state so they come straight off flops.
    h_init_d       = (state_d == ST_INIT);
`ifdef MIDSTATE_EN
    init_sel_d     = (state_d == ST_INIT) && (phase_d == P1);
`else
    init_sel_d     = 1'b0;
`endif
    round_en_d     = (state_d == ST_ROUND);
    h_acc_d        = (state_d == ST_ACC);
    digest_latch_d = (state_d == ST_ACC) && (phase_d == P1);
    busy_d         = (state_d != ST_IDLE);
    hash_valid_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      phase_q        <= P0;
      round_q        <= 6'd0;
      nonce_q        <= 32'd0;
      nonce_end_q    <= 32'd0;
      found_q        <= 1'b0;
      exhausted_q    <= 1'b0;
      h_init_q       <= 1'b0;
      init_sel_q     <= 1'b0;
      round_en_q     <= 1'b0;
      h_acc_q        <= 1'b0;
      digest_latch_q <= 1'b0;
      busy_q         <= 1'b0;
      hash_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      round_q        <= round_d;
      nonce_q        <= nonce_d;
      nonce_end_q    <= nonce_end_d;
      found_q        <= found_d;
      exhausted_q    <= exhausted_d;
      h_init_q       <= h_init_d;
      init_sel_q     <= init_sel_d;
      round_en_q     <= round_en_d;
      h_acc_q        <= h_acc_d;
      digest_latch_q <= digest_latch_d;
      busy_q         <= busy_d;
      hash_valid_q   <= hash_valid_d;
    end
  end

  // An abort arriving in ACC or DONE must not commit the accumulate or report a digest.
  assign h_init       = h_init_q;
  assign init_sel     = init_sel_q;
  assign round_en     = round_en_q;
  assign round        = round_q;
  assign h_acc        = h_acc_q & ~abort;
  assign msg_sel      = phase_q;
  assign digest_latch = digest_latch_q & ~abort;
  assign nonce        = nonce_q;
  assign busy         = busy_q;
  assign hash_valid   = hash_valid_q & ~abort;
  assign found        = found_q;
  assign exhausted    = exhausted_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_mining_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sha256_mining_sequencer: scoreboard bench for the nonce sequencer |
// | (honours MIDSTATE_EN). Rev 1.0                                       |
// +----------------------------------------------------------------------+
module tb_sha256_mining_sequencer;

`ifdef MIDSTATE_EN
  localparam int CPN         = 133;
  localparam int ACC_PER     = 2;
  localparam int FIRST_PHASE = 1;
`else
  localparam int CPN         = 198;
  localparam int ACC_PER     = 3;
  localparam int FIRST_PHASE = 0;
`endif

  logic        clk, rst, start, abort, target_hit;
  logic [31:0] nonce_start, nonce_end, nonce;
  logic        h_init, init_sel, round_en, h_acc, digest_latch;
  logic        busy, hash_valid, found, exhausted;
  logic [5:0]  round;
  logic [1:0]  msg_sel;

  sha256_mining_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target_hit(target_hit),
    .h_init(h_init), .init_sel(init_sel), .round_en(round_en), .round(round),
    .h_acc(h_acc), .msg_sel(msg_sel), .digest_latch(digest_latch), .nonce(nonce),
    .busy(busy), .hash_valid(hash_valid), .found(found), .exhausted(exhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       h_init;
    logic       init_sel;
    logic       round_en;
    logic [5:0] round;
    logic       h_acc;
    logic [1:0] msg_sel;
    logic       digest_latch;
    logic       hash_valid;
  } ev_t;

  ev_t         tbl[$];
  logic [31:0] exp_q[$];
  int n_checks = 0, n_pass = 0;
  int pos = 0, seq_err = 0, hv_cnt = 0, acc_cnt = 0, idle_err = 0;
  logic        hit_en = 1'b0, noise = 1'b0;
  logic [31:0] hit_nonce = 32'd0;

  // Noise outside DONE must be ignored by the sequencer.
  assign target_hit = (hit_en && nonce == hit_nonce) || (noise && !hash_valid);

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Per-nonce strobe schedule: INIT for the first phase and the second hash,
  // 64 rounds, one accumulate per phase (digest capture at chunk 1), then DONE.
  function automatic void build_table();
    ev_t e;
    for (int p = FIRST_PHASE; p <= 2; p++) begin
      if (p == FIRST_PHASE || p == 2) begin
        e = '0; e.h_init = 1'b1; e.init_sel = (p == 1); e.msg_sel = p[1:0];
        tbl.push_back(e);
      end
      for (int r = 0; r < 64; r++) begin
        e = '0; e.round_en = 1'b1; e.round = r[5:0]; e.msg_sel = p[1:0];
        tbl.push_back(e);
      end
      e = '0; e.h_acc = 1'b1; e.digest_latch = (p == 1); e.msg_sel = p[1:0];
      tbl.push_back(e);
    end
    e = '0; e.hash_valid = 1'b1; e.msg_sel = 2'd2;
    tbl.push_back(e);
  endfunction

  always @(negedge clk) begin
    ev_t act;
    int  k;
    act = {h_init, init_sel, round_en, round, h_acc, msg_sel, digest_latch, hash_valid};
    if (rst || !busy) begin
      pos = 0;
      seq_err = 0;
      if (!rst && (h_init || round_en || h_acc || digest_latch || hash_valid || round != 6'd0))
        idle_err++;
    end else begin
      pos++;
      k = (pos - 1) % CPN;
      if (act !== tbl[k]) seq_err++;
      if (h_acc) acc_cnt++;
      if (hash_valid) begin
        hv_cnt++;
        check("strobe_sequence_errors", seq_err, 0);
        seq_err = 0;
        check("hash_valid_cycle", k + 1, CPN);
        check("hash_valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("hashed_nonce", nonce, exp_q.pop_front());
      end
    end
  end

  task automatic run_range(input logic [31:0] ns, input logic [31:0] ne,
                           input logic hen, input logic [31:0] hn);
    logic [31:0] n;
    int          cnt, hv0, acc0;
    logic        exp_found, done;
    n = ns; cnt = 0; exp_found = 1'b0;
    while (1) begin
      exp_q.push_back(n);
      cnt++;
      if (hen && n == hn) begin exp_found = 1'b1; break; end
      if (n == ne) break;
      n = n + 32'd1;
    end
    hit_en = hen; hit_nonce = hn;
    hv0 = hv_cnt; acc0 = acc_cnt;
    nonce_start = ns; nonce_end = ne; start = 1'b1;
    @(negedge clk);
    start = 1'b0; nonce_start = $urandom; nonce_end = $urandom;
    check("busy_with_h_init", {busy, h_init}, 2'b11);
    check("found_cleared", found, 0);
    check("exhausted_cleared", exhausted, 0);
    done = 1'b0;
    for (int i = 0; i < cnt * CPN + 10; i++) begin
      @(negedge clk);
      noise = 1'($urandom_range(0, 1));
      if (!busy) begin done = 1'b1; break; end
    end
    noise = 1'b0; hit_en = 1'b0;
    check("run_completed", done, 1);
    check("found", found, exp_found);
    check("exhausted", exhausted, !exp_found);
    check("final_nonce", nonce, n);
    check("hash_valid_count", hv_cnt - hv0, cnt);
    check("h_acc_count", acc_cnt - acc0, cnt * ACC_PER);
    check("scoreboard_drained", exp_q.size(), 0);
    check("idle_strobes", idle_err, 0);
    exp_q.delete();
  endtask

  task automatic wait_round(input logic [1:0] ph, input logic [5:0] r, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * CPN; i++) begin
      @(negedge clk);
      if (round_en && msg_sel == ph && round == r) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    logic        ok;
    int          hv0, acc0, len;
    logic [31:0] ns;
    build_table();
    rst = 1'b1; start = 1'b0; abort = 1'b0; nonce_start = 32'd0; nonce_end = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_strobes", {h_init, init_sel, round_en, round, h_acc, msg_sel, digest_latch,
                            busy, hash_valid, found, exhausted}, 0);
    check("reset_nonce", nonce, 0);
    rst = 1'b0;
    @(negedge clk);

    run_range(32'd5, 32'd5, 1'b0, 32'd0);
    run_range(32'h10, 32'h13, 1'b1, 32'h12);
    run_range(32'hFFFF_FFFE, 32'h1, 1'b0, 32'd0);

    // Abort during round 10 of the second hash; start pulses while busy ignored.
    hv0 = hv_cnt; acc0 = acc_cnt;
    nonce_start = 32'd100; nonce_end = 32'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    nonce_start = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_round(2'd2, 6'd10, ok);
    check("reached_p2_round10", ok, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_round", round, 0);
    check("abort_nonce_held", nonce, 100);
    repeat (5) @(negedge clk);
    check("abort_no_hash_valid", hv_cnt - hv0, 0);
    check("abort_h_acc_count", acc_cnt - acc0, ACC_PER - 1);
    check("abort_flags", {found, exhausted}, 0);
    abort = 1'b1; start = 1'b1; nonce_start = 32'd55;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_beats_start", busy, 0);
    check("abort_start_nonce", nonce, 100);

    // Asynchronous reset at round 30.
    nonce_start = 32'd300; nonce_end = 32'd300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_round(2'(FIRST_PHASE), 6'd30, ok);
    check("reached_round30", ok, 1);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {h_init, init_sel, round_en, round, h_acc, msg_sel,
                                     digest_latch, busy, hash_valid, found, exhausted}, 0);
    check("async_reset_nonce", nonce, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    run_range(32'd9, 32'd9, 1'b0, 32'd0);

    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 3);
      ns = $urandom;
      if ($urandom_range(0, 2) == 0) ns = 32'hFFFF_FFFF - $urandom_range(0, 2);
      run_range(ns, ns + len - 1, 1'($urandom_range(0, 1)), ns + $urandom_range(0, len - 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_mining_sequencer.md
# sha256_mining_sequencer

Sequences the SHA-256 round datapath and the H0–H7 accumulator registers through the double-SHA-256 of an 80-byte block header, one nonce at a time. It generates:
- the round index and round enables;
- H-register init/accumulate strobes;
- message-chunk select;
- the nonce stream for the range the host gives it.

It stops on the first winning nonce, on range exhaustion, or on host abort. It sits between the host command interface and the hash core.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE; latches nonce_start/nonce_end
- abort  in  1  level; any non-IDLE state → IDLE on next edge
- nonce_start  in  32  first nonce of range
- nonce_end  in  32  last nonce of range (inclusive)
- target_hit  in  1  comparator result for final digest; sampled only in DONE
- h_init  out  1  pulse: load H registers from init_sel source
- init_sel  out  1  0 = SHA-256 IV, 1 = precomputed midstate
- round_en  out  1  high during each of the 64 compression rounds
- round  out  6  round index 0..63; 0 outside ROUND
- h_acc  out  1  pulse: H ← H + working vars (end of compression)
- msg_sel  out  2  0 = header chunk 0, 1 = header chunk 1 + padding, 2 = first digest + padding
- digest_latch  out  1  pulse: capture first-hash digest as message for phase 2 (equals h_acc in phase 1)
- nonce  out  32  nonce currently being hashed
- busy  out  1  high in every state except IDLE
- hash_valid  out  1  one-cycle pulse in DONE; final digest is stable
- found  out  1  sticky until next accepted start; nonce holds winning value
- exhausted  out  1  sticky until next accepted start; range finished without hit

## Operation
- States: IDLE, INIT, ROUND, ACC, DONE.
- Phases: P0 = chunk 0, P1 = chunk 1, P2 = second hash. msg_sel equals the phase number.
- IDLE + start:
  - nonce ← nonce_start; clear found/exhausted.
  - Go to INIT with phase P0 (P1 if MIDSTATE_EN).
- INIT:
  - h_init=1.
  - init_sel=1 only for P1 under MIDSTATE_EN; otherwise 0.
  - → ROUND, round=0.
- ROUND: round_en=1; round increments each cycle; at round 63 → ACC.
- ACC: h_acc=1, then by phase:
  - P0 → ROUND (P1, no INIT; H chains).
  - P1 → digest_latch=1 → INIT (P2).
  - P2 → DONE.
- DONE: hash_valid=1; then the first matching case applies:
  - target_hit → found=1, nonce held → IDLE.
  - nonce == nonce_end → exhausted=1 → IDLE.
  - otherwise nonce ← nonce+1 (mod 2^32) → INIT of first phase.
- Wrap-around:
  - nonce_end < nonce_start wraps through 0xFFFFFFFF→0.
  - Exactly ((nonce_end − nonce_start) mod 2^32) + 1 nonces are hashed.
- Abort:
  - Takes priority over every transition.
  - → IDLE; found/exhausted unchanged; nonce holds last value.
  - No h_acc or hash_valid is issued on the abort cycle.
- start while busy: ignored.
- start coincident with abort in IDLE: abort wins, start ignored.

## Timing
- Reset values: all outputs 0; state IDLE; phase P0.
- start edge → h_init in the following cycle; busy rises the same cycle as h_init.
- Cycles per nonce, DONE inclusive:
  - Without MIDSTATE_EN: 198 (66 P0 + 65 P1 + 66 P2 + 1 DONE).
  - With MIDSTATE_EN: 133 (66 P1 + 66 P2 + 1 DONE).
- First hash_valid after start: cycle 198 (or 133), counting the h_init cycle as 1.
- found/exhausted rise on the edge leaving DONE; busy falls the same edge.
- msg_sel changes only on the edge entering INIT, or on ACC→ROUND (P0→P1). It is stable for all 64 rounds of a phase.
- Reset mid-operation: immediate return to reset values; no partial strobes.

## Configuration
- MIDSTATE_EN defined:
  - P0 is never executed.
  - Each nonce starts at INIT of P1 with init_sel=1; the host supplies the chunk-0 midstate.
  - msg_sel never equals 0.
- MIDSTATE_EN undefined:
  - Full three-compression sequence per nonce.
  - init_sel tied 0.

## Test plan
- Reset mid-ROUND (round=30) → all outputs 0 next cycle; a later start runs a full clean sequence.
- start, nonce_start=5, nonce_end=5, target_hit=0:
  - exactly one hash_valid, at cycle 198 (133 with MIDSTATE_EN);
  - exhausted=1; nonce=5; three h_acc pulses (two with MIDSTATE_EN).
- Range 0x10..0x13, target_hit=1 only while nonce=0x12 → three hash_valid pulses; found=1; nonce=0x12; exhausted=0.
- Wrap range 0xFFFFFFFE..0x00000001, no hit → nonces FFFFFFFE, FFFFFFFF, 0, 1 each hashed once; exhausted=1.
- abort asserted on round 10 of P2 → IDLE next edge; busy=0; no h_acc and no hash_valid; start pulses during busy ignored.
- Strobe ordering check per nonce:
  - h_init, 64×round_en, h_acc, 64×round_en, h_acc+digest_latch, h_init, 64×round_en, h_acc, hash_valid;
  - msg_sel 0,1,2 respectively.
